// File: rtl/regfile_wr_decoder.sv
// Write-side front end of the register file: buffers write requests in a small FIFO and
// retires one per cycle as a registered one-hot enable. Optional forwarding: REGFILE_WR_FWD_EN.
module regfile_wr_decoder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     commit_hold,
  output logic [(2**ADDR_W)-1:0]   we_onehot,
  output logic [DATA_W-1:0]        wdata_out,
  output logic                     zero_drop,
  output logic                     busy,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic [NREG-1:0]   we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              zdrop_q, zdrop_d;
  logic              busy_q, busy_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Next-state: push/pop bookkeeping and commit-stage decode of the FIFO head
  always_comb begin
    push      = wr_valid & ready_q;
    pop       = (count_q != '0) & ~commit_hold;
    head_addr = addr_mem[rd_ptr_q];
    head_data = data_mem[rd_ptr_q];

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    we_d      = '0;
    zdrop_d   = 1'b0;
    wdata_d   = wdata_q;
    caddr_d   = caddr_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wdata_d  = head_data;
      caddr_d  = head_addr;
      if (head_addr == ADDR_W'(ZERO_REG)) zdrop_d = 1'b1;
      else                                we_d    = NREG'(1) << head_addr;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // Ready for the next cycle follows the count that will be registered at this edge
    ready_d = (count_d != CNT_W'(DEPTH));
    busy_d  = (count_d != '0) | pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= '0;
      wdata_q  <= '0;
      caddr_q  <= '0;
      zdrop_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      caddr_q  <= caddr_d;
      zdrop_q  <= zdrop_d;
      busy_q   <= busy_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready  = ready_q;
  assign we_onehot = we_q;
  assign wdata_out = wdata_q;
  assign zero_drop = zdrop_q;
  assign busy      = busy_q;

`ifdef REGFILE_WR_FWD_EN
  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;
  logic [PTR_W-1:0]  fwd_idx;

  // Youngest match wins: commit stage first, then FIFO entries oldest to newest override
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = rd_ptr_q;
    if (rd_addr != ADDR_W'(ZERO_REG)) begin
      if ((we_q != '0) && (caddr_q == rd_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = wdata_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (addr_mem[fwd_idx] == rd_addr)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = data_mem[fwd_idx];
        end
      end
    end
  end

  assign fwd_hit  = fwd_hit_c;
  assign fwd_data = fwd_data_c;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rd_addr, caddr_q};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Randomized and directed bench for regfile_wr_decoder against a queue-based model.
module tb_regfile_wr_decoder;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ZREG   = 31;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              commit_hold = 1'b0;
  logic [31:0]       we_onehot;
  logic [DATA_W-1:0] wdata_out;
  logic              zero_drop;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wr_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZREG), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_hold(commit_hold),
    .we_onehot(we_onehot), .wdata_out(wdata_out), .zero_drop(zero_drop), .busy(busy),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } req_t;

  req_t              mq[$];
  logic [31:0]       exp_we = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic              exp_zd = 1'b0;
  logic              exp_busy = 1'b0;
  logic [ADDR_W-1:0] exp_caddr = '0;
  bit                ready_ok = 1'b0;
  bit                last_push = 1'b0;

  function automatic bit exp_ready();
    return ready_ok && (mq.size() < DEPTH);
  endfunction

  // Advance one clock and update the model with the same edge's push/pop decisions
  task automatic cycle();
    bit   push, pop;
    req_t n, h;
    push = wr_valid && exp_ready();
    pop  = (mq.size() != 0) && !commit_hold;
    n.a  = wr_addr;
    n.d  = wr_data;
    @(posedge clk);
    last_push = push;
    if (pop) begin
      h         = mq.pop_front();
      exp_zd    = (h.a == ADDR_W'(ZREG));
      exp_we    = exp_zd ? 32'h0 : (32'h1 << h.a);
      exp_wdata = h.d;
      exp_caddr = h.a;
    end else begin
      exp_we = '0;
      exp_zd = 1'b0;
    end
    if (push) mq.push_back(n);
    exp_busy = (mq.size() != 0) || pop;
    ready_ok = 1'b1;
    #1;
  endtask

  function automatic void fwd_model(input logic [ADDR_W-1:0] ra, output logic hit,
                                    output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != ADDR_W'(ZREG)) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].a == ra) begin
          hit = 1'b1;
          d   = mq[i].d;
        end
      end
      if (!hit && exp_we != 0 && exp_caddr == ra) begin
        hit = 1'b1;
        d   = exp_wdata;
      end
    end
`ifndef REGFILE_WR_FWD_EN
    hit = 1'b0;
    d   = '0;
`endif
  endfunction

  task automatic drain();
    wr_valid    = 1'b0;
    commit_hold = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (we_onehot !== 32'h0) begin tests_failed++; $display("FAIL reset_we got=%h exp=0", we_onehot); end
    tests_run++; if (wdata_out !== 64'h0) begin tests_failed++; $display("FAIL reset_wdata got=%h exp=0", wdata_out); end
    tests_run++; if (zero_drop !== 1'b0) begin tests_failed++; $display("FAIL reset_zd got=%b exp=0", zero_drop); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n  = 1'b1;
    ready_ok = 1'b0;
    cycle();
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy2 got=%b exp=0", busy); end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD;
    cycle();
    wr_valid = 1'b0;
    tests_run++; if (we_onehot !== 32'h0) begin tests_failed++; $display("FAIL single_early got=%h exp=0", we_onehot); end
    cycle();
    tests_run++; if (we_onehot !== 32'h8) begin tests_failed++; $display("FAIL single_we got=%h exp=8", we_onehot); end
    tests_run++; if (wdata_out !== 64'hDEAD) begin tests_failed++; $display("FAIL single_wdata got=%h exp=dead", wdata_out); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got=%b exp=1", busy); end
    cycle();
    tests_run++; if (we_onehot !== 32'h0) begin tests_failed++; $display("FAIL single_off got=%h exp=0", we_onehot); end
    tests_run++; if (wdata_out !== 64'hDEAD) begin tests_failed++; $display("FAIL single_hold got=%h exp=dead", wdata_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_zero_reg();
    wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 64'h5;
    cycle();
    wr_valid = 1'b0;
    cycle();
    tests_run++; if (we_onehot !== 32'h0) begin tests_failed++; $display("FAIL zero_we got=%h exp=0", we_onehot); end
    tests_run++; if (zero_drop !== 1'b1) begin tests_failed++; $display("FAIL zero_pulse got=%b exp=1", zero_drop); end
    tests_run++; if (wdata_out !== 64'h5) begin tests_failed++; $display("FAIL zero_wdata got=%h exp=5", wdata_out); end
    cycle();
    tests_run++; if (zero_drop !== 1'b0) begin tests_failed++; $display("FAIL zero_clear got=%b exp=0", zero_drop); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got=%b exp=0", busy); end
  endtask

  task automatic test_hold_stall();
    commit_hold = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 64'h11;
    cycle();
    wr_addr = 5'd2; wr_data = 64'h22;
    cycle();
    wr_addr = 5'd4; wr_data = 64'h44;
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready got=%b exp=0", wr_ready); end
    cycle();
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready2 got=%b exp=0", wr_ready); end
    tests_run++; if (we_onehot !== 32'h0) begin tests_failed++; $display("FAIL stall_we got=%h exp=0", we_onehot); end
    commit_hold = 1'b0;
    cycle();
    tests_run++; if (we_onehot !== 32'h2) begin tests_failed++; $display("FAIL drain1 got=%h exp=2", we_onehot); end
    cycle();
    wr_valid = 1'b0;
    tests_run++; if (we_onehot !== 32'h4) begin tests_failed++; $display("FAIL drain2 got=%h exp=4", we_onehot); end
    cycle();
    tests_run++; if (we_onehot !== 32'h10 || wdata_out !== 64'h44) begin
      tests_failed++; $display("FAIL drain3 got=%h/%h exp=10/44", we_onehot, wdata_out);
    end
    cycle();
    tests_run++; if (busy !== 1'b0 || we_onehot !== 32'h0) begin
      tests_failed++; $display("FAIL drain_idle got=%b/%h exp=0/0", busy, we_onehot);
    end
  endtask

  task automatic test_reset_mid();
    commit_hold = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    cycle();
    wr_addr = 5'd10; wr_data = 64'hAA;
    cycle();
    wr_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    mq.delete();
    exp_we = '0; exp_zd = 1'b0; exp_busy = 1'b0; exp_wdata = '0; ready_ok = 1'b0;
    tests_run++; if (busy !== 1'b0 || we_onehot !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_now got=%b/%h exp=0/0", busy, we_onehot);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    commit_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests_run++; if (we_onehot !== 32'h0 || busy !== 1'b0 || zero_drop !== 1'b0) begin
        tests_failed++; $display("FAIL rstmid_c%0d got=%h/%b/%b exp=0/0/0", i, we_onehot, busy, zero_drop);
      end
    end
  endtask

  task automatic test_forward();
    commit_hold = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'hA;
    cycle();
    wr_data = 64'hB;
    cycle();
    wr_valid = 1'b0;
    rd_addr = 5'd7;
    #1;
`ifdef REGFILE_WR_FWD_EN
    tests_run++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hB) begin
      tests_failed++; $display("FAIL fwd_hit got=%b/%h exp=1/b", fwd_hit, fwd_data);
    end
`else
    tests_run++; if (fwd_hit !== 1'b0 || fwd_data !== 64'h0) begin
      tests_failed++; $display("FAIL fwd_off got=%b/%h exp=0/0", fwd_hit, fwd_data);
    end
`endif
    rd_addr = 5'd8;
    #1;
    tests_run++; if (fwd_hit !== 1'b0) begin tests_failed++; $display("FAIL fwd_miss got=%b exp=0", fwd_hit); end
    drain();
  endtask

  task automatic test_random();
    logic              eh;
    logic [DATA_W-1:0] ed;
    for (int n = 0; n < 400; n++) begin
      wr_valid    = ($urandom_range(0, 99) < 70);
      wr_addr     = ($urandom_range(0, 9) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 31));
      wr_data     = {$urandom(), $urandom()};
      commit_hold = ($urandom_range(0, 99) < 30);
      tests_run++; if (wr_ready !== exp_ready()) begin
        tests_failed++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, wr_ready, exp_ready());
      end
      cycle();
      rd_addr = ($urandom_range(0, 1) == 0 && mq.size() != 0) ? mq[0].a : ADDR_W'($urandom_range(0, 31));
      #1;
      fwd_model(rd_addr, eh, ed);
      tests_run++; if (we_onehot !== exp_we || zero_drop !== exp_zd || wdata_out !== exp_wdata || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL rnd_out n=%0d got=%h/%b/%h/%b exp=%h/%b/%h/%b", n, we_onehot, zero_drop, wdata_out, busy,
                 exp_we, exp_zd, exp_wdata, exp_busy);
      end
      tests_run++; if ($countones(we_onehot) > 1) begin
        tests_failed++; $display("FAIL rnd_onehot n=%0d got=%h exp=<=1 bit", n, we_onehot);
      end
      tests_run++; if (fwd_hit !== eh || fwd_data !== ed) begin
        tests_failed++; $display("FAIL rnd_fwd n=%0d got=%b/%h exp=%b/%h", n, fwd_hit, fwd_data, eh, ed);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_zero_reg();
    test_hold_stall();
    test_reset_mid();
    test_forward();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
